turfio_cout_tx: RTL



---
 rtl/turfio_cout_tx.sv | 123 ++++++++++++
 1 files changed

// File: rtl/turfio_cout_tx.sv
// rtl/turfio_cout_tx.sv - TURFIO 4:1 command transmit framer, 32-bit words as 8 nibbles MSB first
// Optional 2-entry command FIFO enabled by defining TURFIO_COUT_TX_FIFO_EN.
module turfio_cout_tx #(
  parameter logic        INV           = 1'b0,
  parameter logic [31:0] TRAIN_PATTERN = 32'hA55A6996,
  parameter logic [31:0] IDLE_PATTERN  = 32'h00000000
) (
  input  logic        if_clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        train_i,
  input  logic [31:0] cmd_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  output logic [3:0]  data_o,
  output logic        word_start_o,
  output logic        training_o,
  output logic [15:0] sent_count_o
);

  logic [2:0]  phase;
  logic [31:0] shift;
  logic        load;
  logic        push;
  logic        have_word;
  logic [31:0] next_word;
  logic [31:0] word_sel;
  logic        word_train;

  assign load = (phase == 3'd7);
  assign push = cmd_valid_i && cmd_ready_o && !rst_i;

`ifdef TURFIO_COUT_TX_FIFO_EN
  logic [31:0] fifo0;
  logic [31:0] fifo1;
  logic [1:0]  fifo_cnt;
  logic        fifo_pop;
  logic        bypass;

  assign cmd_ready_o = (fifo_cnt != 2'd2) && en_i;
  assign fifo_pop    = load && !train_i && (fifo_cnt != 2'd0);
  // An empty FIFO hands a phase-7 push straight to the shifter.
  assign bypass      = load && !train_i && (fifo_cnt == 2'd0) && push;
  assign have_word   = fifo_pop || bypass;
  assign next_word   = fifo_pop ? fifo0 : cmd_i;

  always_ff @(posedge if_clk_i) begin
    if (rst_i) begin
      fifo_cnt <= 2'd0;
      fifo0    <= 32'h0;
      fifo1    <= 32'h0;
    end else if (!bypass) begin
      case (fifo_cnt)
        2'd0: begin
          if (push) begin
            fifo0    <= cmd_i;
            fifo_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (fifo_pop && push) begin
            fifo0 <= cmd_i;
          end else if (fifo_pop) begin
            fifo_cnt <= 2'd0;
          end else if (push) begin
            fifo1    <= cmd_i;
            fifo_cnt <= 2'd2;
          end
        end
        default: begin
          if (fifo_pop) begin
            fifo0    <= fifo1;
            fifo_cnt <= 2'd1;
          end
        end
      endcase
    end
  end
`else
  assign cmd_ready_o = load && en_i && !train_i;
  assign have_word   = push;
  assign next_word   = cmd_i;
`endif

  always_comb begin
    word_sel   = IDLE_PATTERN;
    word_train = 1'b0;
    if (train_i) begin
      word_sel   = TRAIN_PATTERN;
      word_train = 1'b1;
    end else if (have_word) begin
      word_sel = next_word;
    end
  end

  // The load cycle drives nibble 0 directly, so the shifter keeps only the remaining 7.
  always_ff @(posedge if_clk_i) begin
    if (rst_i) begin
      phase        <= 3'd7;
      shift        <= IDLE_PATTERN;
      data_o       <= {4{INV}};
      word_start_o <= 1'b0;
      training_o   <= 1'b0;
      sent_count_o <= 16'h0000;
    end else begin
      phase <= phase + 3'd1;
      if (push) begin
        sent_count_o <= sent_count_o + 16'd1;
      end
      if (load) begin
        data_o       <= word_sel[31:28] ^ {4{INV}};
        shift        <= {word_sel[27:0], 4'h0};
        word_start_o <= 1'b1;
        training_o   <= word_train;
      end else begin
        data_o       <= shift[31:28] ^ {4{INV}};
        shift        <= {shift[27:0], 4'h0};
        word_start_o <= 1'b0;
      end
    end
  end

endmodule
